// File: rtl/mac_pipe.sv
// Three-stage signed multiply-add with saturating accumulate mode.
// Ready/valid on both sides; one shared advance enable stalls the whole pipe.
module mac_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] c,
    input  logic                         mode,
    input  logic                         first,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  q,
    output logic                         ovf
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int EW = OUT_WIDTH + 2;

    // Out of range iff the bits from the result sign upward are not all equal.
    function automatic logic sat_ovf(input logic [EW-1:0] x);
        sat_ovf = !((&x[EW-1:OUT_WIDTH-1]) || !(|x[EW-1:OUT_WIDTH-1]));
    endfunction

    function automatic logic [OUT_WIDTH-1:0] sat_val(input logic [EW-1:0] x);
        if (sat_ovf(x)) begin
            if (x[EW-1]) begin
                sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            end else begin
                sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end else begin
            sat_val = x[OUT_WIDTH-1:0];
        end
    endfunction

    logic                         w_advance;

    logic                         r_s1_valid;
    logic signed [DATA_WIDTH-1:0] r_s1_a;
    logic signed [DATA_WIDTH-1:0] r_s1_b;
    logic signed [DATA_WIDTH-1:0] r_s1_c;
    logic                         r_s1_mode;
    logic                         r_s1_first;

    logic signed [PW-1:0]         w_prod;

    logic                         r_s2_valid;
    logic signed [PW-1:0]         r_s2_p;
    logic signed [DATA_WIDTH-1:0] r_s2_c;
    logic                         r_s2_mode;
    logic                         r_s2_first;

    logic signed [EW-1:0]         w_base;
    logic signed [EW-1:0]         w_sum;
    logic [OUT_WIDTH-1:0]         w_res;
    logic                         w_ovf;

    logic signed [OUT_WIDTH-1:0]  r_acc;
    logic signed [OUT_WIDTH-1:0]  r_q;
    logic                         r_ovf;
    logic                         r_out_valid;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign ovf       = r_ovf;

    // Stage 1: operand capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_first <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_c     <= c;
            r_s1_mode  <= mode;
            r_s1_first <= first;
        end
    end

    assign w_prod = PW'(r_s1_a) * PW'(r_s1_b);

    // Stage 2: product register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_p     <= '0;
            r_s2_c     <= '0;
            r_s2_mode  <= 1'b0;
            r_s2_first <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_p     <= w_prod;
            r_s2_c     <= r_s1_c;
            r_s2_mode  <= r_s1_mode;
            r_s2_first <= r_s1_first;
        end
    end

    // Stage 3 adder: continuing an ACC chain adds to acc, everything else adds c.
    always_comb begin
        w_base = '0;
        if (r_s2_mode && !r_s2_first) begin
            w_base = EW'(r_acc);
        end else begin
            w_base = EW'(r_s2_c);
        end
        w_sum = w_base + EW'(r_s2_p);
        w_ovf = sat_ovf(w_sum);
        w_res = sat_val(w_sum);
    end

    // Stage 3: result, overflow flag and accumulator.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_q   <= w_res;
                r_ovf <= w_ovf;
                if (r_s2_mode) begin
                    r_acc <= w_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench for mac_pipe: expectations come from an integer model at
// acceptance time and are checked in order as outputs are transferred.
module tb_mac_pipe;

    localparam int  DW   = 8;
    localparam int  OW   = 16;
    localparam longint MAXV = (64'sd1 <<< (OW - 1)) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< (OW - 1));

    logic                 clk;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic signed [DW-1:0] c;
    logic                 mode;
    logic                 first;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] q;
    logic                 ovf;

    typedef struct {
        longint q;
        longint ovf;
    } sb_item_t;

    sb_item_t sb[$];
    longint   m_acc;
    int       n_tests;
    int       n_fail;
    logic signed [OW-1:0] held_q;
    logic                 hold_vld;

    mac_pipe #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .mode      (mode),
        .first     (first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one sample starting just after a rising edge; returns just after it is accepted.
    task automatic send(input int ta, input int tb, input int tc, input logic tm, input logic tf);
        bit     acc_ok;
        longint p;
        longint s;
        sb_item_t e;
        acc_ok   = 1'b0;
        a        = DW'(ta);
        b        = DW'(tb);
        c        = DW'(tc);
        mode     = tm;
        first    = tf;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_ok = 1'b1;
                break;
            end
        end
        if (!acc_ok) begin
            check_eq("send_timeout", 0, 1);
        end else begin
            p = longint'(a) * longint'(b);
            if (tm && !tf) s = m_acc + p;
            else           s = longint'(c) + p;
            e.ovf = 0;
            if (s > MAXV) begin
                s = MAXV;
                e.ovf = 1;
            end else if (s < MINV) begin
                s = MINV;
                e.ovf = 1;
            end
            if (tm) m_acc = s;
            e.q = s;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        #1;
        check_eq("drain_empty", sb.size(), 0);
    endtask

    // Output monitor: handshake rule, hold-under-stall, and in-order scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            check_eq("in_ready", in_ready, (!out_valid || out_ready));
            if (out_valid && !out_ready) begin
                if (hold_vld) check_eq("q_hold", q, held_q);
                held_q   <= q;
                hold_vld <= 1'b1;
            end else begin
                hold_vld <= 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", q, 64'sh7fff_ffff);
                end else begin
                    check_eq("q", q, sb[0].q);
                    check_eq("ovf", ovf, sb[0].ovf);
                    sb.delete(0);
                end
            end
        end else begin
            hold_vld <= 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_acc     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        a         = '0;
        b         = '0;
        c         = '0;
        mode      = 1'b0;
        first     = 1'b0;
        out_ready = 1'b1;

        // Reset held two edges with in_valid high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_q", q, 0);
        check_eq("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_no_out", out_valid, 0);
        repeat (4) @(posedge clk);
        #1;

        // MADD corners; output valid in the third cycle after the sample is presented.
        send(-128, -128, 127, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check_eq("lat_early", out_valid, 0);
        end
        @(negedge clk);
        check_eq("lat_valid", out_valid, 1);
        @(posedge clk);
        #1;
        send(127, -128, -128, 1'b0, 1'b0);
        drain();

        // Back-to-back streaming.
        send(1, 2, 3, 1'b0, 1'b0);
        send(4, 5, 6, 1'b0, 1'b0);
        send(-7, 8, 9, 1'b0, 1'b0);
        send(0, 0, -1, 1'b0, 1'b0);
        drain();

        // Backpressure window while streaming six samples.
        fork
            begin
                for (int i = 0; i < 6; i++) send(i * 13 - 20, 7 - 3 * i, i * 5, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // ACC saturation chain.
        send(127, 127, 0, 1'b1, 1'b1);
        send(127, 127, 0, 1'b1, 1'b0);
        send(127, 127, 0, 1'b1, 1'b0);
        send(-128, 127, 0, 1'b1, 1'b0);
        drain();

        // ACC restart after reset with items in flight.
        send(10, 10, 5, 1'b1, 1'b1);
        send(3, 4, 0, 1'b1, 1'b0);
        send(1, 1, 0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        m_acc = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst2_no_out", out_valid, 0);
        @(posedge clk);
        #1;
        send(2, 3, 9, 1'b1, 1'b0);
        drain();

        // Mixed random traffic under random backpressure.
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                         int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0));
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
